// File: rtl/cordic_pkg.sv
// Shared width and occupancy-state definitions for the CORDIC output stage.
package cordic_pkg;

    localparam int IDWIDTH = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_t;

endpackage

// File: rtl/stage5_output_if.sv
// Bundle of the stage5 input handshake, output handshake and status signals.
interface stage5_output_if
    import cordic_pkg::*;
#(
    parameter int DWIDTH = IDWIDTH
);

    logic [DWIDTH-1:0] Xin;
    logic [DWIDTH-1:0] Yin;
    logic              in_valid;
    logic              in_ready;
    logic [DWIDTH-1:0] cosh_o;
    logic [DWIDTH-1:0] sinh_o;
    logic [DWIDTH-1:0] exp_o;
    logic [DWIDTH-1:0] expn_o;
    logic              ovf_o;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       sat_cnt;

    // master: upstream/downstream environment; slave: the stage itself
    modport master (
        output Xin, Yin, in_valid, out_ready,
        input  in_ready, cosh_o, sinh_o, exp_o, expn_o, ovf_o, out_valid, sat_cnt
    );

    modport slave (
        input  Xin, Yin, in_valid, out_ready,
        output in_ready, cosh_o, sinh_o, exp_o, expn_o, ovf_o, out_valid, sat_cnt
    );

endinterface

// File: rtl/satAddSub.sv
// Saturating signed add/subtract: full-precision result at DWIDTH+1 bits, clamped to DWIDTH.
module satAddSub
    import cordic_pkg::*;
#(
    parameter int DWIDTH = IDWIDTH
) (
    input  logic [DWIDTH-1:0] iData1,
    input  logic [DWIDTH-1:0] iData2,
    input  logic              iSub,
    output logic [DWIDTH-1:0] oData,
    output logic              oOvf
);

    localparam logic signed [DWIDTH:0] SAT_MAX = {2'b00, {(DWIDTH-1){1'b1}}};
    localparam logic signed [DWIDTH:0] SAT_MIN = {2'b11, {(DWIDTH-1){1'b0}}};

    logic signed [DWIDTH:0] ext1;
    logic signed [DWIDTH:0] ext2;
    logic signed [DWIDTH:0] full;

    always_comb begin
        ext1  = {iData1[DWIDTH-1], iData1};
        ext2  = {iData2[DWIDTH-1], iData2};
        full  = iSub ? (ext1 - ext2) : (ext1 + ext2);
        oData = full[DWIDTH-1:0];
        oOvf  = 1'b0;
        if (full > SAT_MAX) begin
            oData = SAT_MAX[DWIDTH-1:0];
            oOvf  = 1'b1;
        end else if (full < SAT_MIN) begin
            oData = SAT_MIN[DWIDTH-1:0];
            oOvf  = 1'b1;
        end
    end

endmodule

// File: rtl/stage5_output.sv
// CORDIC output stage: forms sat(X+Y) and sat(X-Y) and buffers results in a 2-entry skid FIFO.
module stage5_output
    import cordic_pkg::*;
#(
    parameter int DWIDTH = IDWIDTH
) (
    input  logic            clk,
    input  logic            rst,
    stage5_output_if.slave  bus
);

    typedef struct packed {
        logic [DWIDTH-1:0] cosh;
        logic [DWIDTH-1:0] sinh;
        logic [DWIDTH-1:0] exp_v;
        logic [DWIDTH-1:0] expn_v;
        logic              ovf;
    } entry_t;

    occ_state_t        state_reg;
    occ_state_t        state_next;
    entry_t            entry_reg [2];
    entry_t            new_entry;
    logic [15:0]       sat_cnt_reg;
    logic [DWIDTH-1:0] res_data [2];
    logic [1:0]        res_ovf;
    logic              in_ready;
    logic              out_valid;
    logic              push;
    logic              pop;

    // Instance 0 forms X+Y (exp), instance 1 forms X-Y (exp of negative argument)
    for (genvar gi = 0; gi < 2; gi++) begin : g_addsub
        satAddSub #(.DWIDTH(DWIDTH)) u_sat (
            .iData1 (bus.Xin),
            .iData2 (bus.Yin),
            .iSub   (gi == 1),
            .oData  (res_data[gi]),
            .oOvf   (res_ovf[gi])
        );
    end

    // Handshake decoded from registered state only, so in_ready has no out_ready path
    assign in_ready  = (state_reg != TWO);
    assign out_valid = (state_reg != EMPTY);
    assign push      = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready;

    always_comb begin
        new_entry.cosh   = bus.Xin;
        new_entry.sinh   = bus.Yin;
        new_entry.exp_v  = res_data[0];
        new_entry.expn_v = res_data[1];
        new_entry.ovf    = |res_ovf;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY:   if (push) state_next = ONE;
            ONE: begin
                if (push && !pop)      state_next = TWO;
                else if (pop && !push) state_next = EMPTY;
            end
            TWO:     if (pop) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    // Slot 0 is always the head; slot 1 only holds the second-oldest entry in TWO
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= EMPTY;
            sat_cnt_reg <= '0;
            for (int i = 0; i < 2; i++) entry_reg[i] <= '0;
        end else begin
            state_reg <= state_next;
            if (push && new_entry.ovf && (sat_cnt_reg != 16'hFFFF))
                sat_cnt_reg <= sat_cnt_reg + 16'd1;
            case (state_reg)
                EMPTY: if (push) entry_reg[0] <= new_entry;
                ONE: begin
                    if (push && pop) entry_reg[0] <= new_entry;
                    else if (push)   entry_reg[1] <= new_entry;
                end
                TWO:   if (pop) entry_reg[0] <= entry_reg[1];
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.cosh_o    = entry_reg[0].cosh;
    assign bus.sinh_o    = entry_reg[0].sinh;
    assign bus.exp_o     = entry_reg[0].exp_v;
    assign bus.expn_o    = entry_reg[0].expn_v;
    assign bus.ovf_o     = entry_reg[0].ovf;
    assign bus.sat_cnt   = sat_cnt_reg;

endmodule

// File: tb/tb_stage5_output.sv
// Bench for stage5_output: queue-based reference model checked every cycle, plus directed literal checks.
module tb_stage5_output;
    import cordic_pkg::*;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stage5_output_if #(.DWIDTH(DW)) bus();

    stage5_output #(.DWIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] cosh;
        logic [15:0] sinh;
        logic [15:0] exp_v;
        logic [15:0] expn_v;
        logic        ovf;
    } item_t;

    item_t model_q[$];
    int    model_cnt = 0;
    bit    live      = 1'b0;
    int    total     = 0;
    int    passed    = 0;

    function automatic item_t predict(logic [15:0] x, logic [15:0] y);
        item_t it;
        int a, b, s, d;
        a = int'($signed(x));
        b = int'($signed(y));
        s = a + b;
        d = a - b;
        it.ovf = 1'b0;
        if (s > 32767)       begin s = 32767;  it.ovf = 1'b1; end
        else if (s < -32768) begin s = -32768; it.ovf = 1'b1; end
        if (d > 32767)       begin d = 32767;  it.ovf = 1'b1; end
        else if (d < -32768) begin d = -32768; it.ovf = 1'b1; end
        it.cosh   = x;
        it.sinh   = y;
        it.exp_v  = s[15:0];
        it.expn_v = d[15:0];
        return it;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic drive(bit v, logic [15:0] x, logic [15:0] y, bit ordy);
        bus.in_valid  = v;
        bus.Xin       = x;
        bus.Yin       = y;
        bus.out_ready = ordy;
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    // Reference model: FIFO of at most two results, updated on each rising edge
    initial forever begin
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            model_cnt = 0;
            live      = 1'b1;
        end else if (live) begin
            bit do_push, do_pop;
            item_t it;
            do_push = bus.in_valid && (model_q.size() < 2);
            do_pop  = (model_q.size() > 0) && bus.out_ready;
            it      = predict(bus.Xin, bus.Yin);
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                model_q.push_back(it);
                if (it.ovf && model_cnt < 65535) model_cnt++;
            end
        end
    end

    // Per-cycle comparison against the model, on the falling edge
    initial forever begin
        @(negedge clk);
        if (live) begin
            chk("in_ready", 32'(bus.in_ready), 32'(model_q.size() < 2));
            chk("out_valid", 32'(bus.out_valid), 32'(model_q.size() != 0));
            chk("sat_cnt", 32'(bus.sat_cnt), model_cnt);
            if (model_q.size() != 0) begin
                chk("cosh_o", 32'(bus.cosh_o), 32'(model_q[0].cosh));
                chk("sinh_o", 32'(bus.sinh_o), 32'(model_q[0].sinh));
                chk("exp_o",  32'(bus.exp_o),  32'(model_q[0].exp_v));
                chk("expn_o", 32'(bus.expn_o), 32'(model_q[0].expn_v));
                chk("ovf_o",  32'(bus.ovf_o),  32'(model_q[0].ovf));
            end
        end
    end

    initial begin
        drive(1'b0, 16'h0000, 16'h0000, 1'b0);
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        $display("txn reset");
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_sat_cnt",   32'(bus.sat_cnt),   32'd0);
        chk("rst_cosh_o",    32'(bus.cosh_o),    32'd0);
        chk("rst_exp_o",     32'(bus.exp_o),     32'd0);
        chk("rst_expn_o",    32'(bus.expn_o),    32'd0);

        $display("txn X=4000 Y=0000");
        drive(1'b1, 16'h4000, 16'h0000, 1'b1);
        tick;
        chk("t1_exp_o",     32'(bus.exp_o),     32'h4000);
        chk("t1_expn_o",    32'(bus.expn_o),    32'h4000);
        chk("t1_ovf_o",     32'(bus.ovf_o),     32'd0);
        chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
        drive(1'b0, 16'h0000, 16'h0000, 1'b1);
        tick;

        $display("txn X=6000 Y=3000");
        drive(1'b1, 16'h6000, 16'h3000, 1'b1);
        tick;
        chk("t2_exp_o",   32'(bus.exp_o),   32'h7FFF);
        chk("t2_expn_o",  32'(bus.expn_o),  32'h3000);
        chk("t2_ovf_o",   32'(bus.ovf_o),   32'd1);
        chk("t2_sat_cnt", 32'(bus.sat_cnt), 32'd1);
        drive(1'b0, 16'h0000, 16'h0000, 1'b1);
        tick;

        $display("txn X=C000 Y=7000");
        drive(1'b1, 16'hC000, 16'h7000, 1'b1);
        tick;
        chk("t3_exp_o",   32'(bus.exp_o),   32'h3000);
        chk("t3_expn_o",  32'(bus.expn_o),  32'h8000);
        chk("t3_ovf_o",   32'(bus.ovf_o),   32'd1);
        chk("t3_sat_cnt", 32'(bus.sat_cnt), 32'd2);

        // Exactly -2^15 is representable and must not flag overflow
        $display("txn X=C000 Y=4000");
        drive(1'b1, 16'hC000, 16'h4000, 1'b1);
        tick;
        chk("t4_exp_o",  32'(bus.exp_o),  32'h0000);
        chk("t4_expn_o", 32'(bus.expn_o), 32'h8000);
        chk("t4_ovf_o",  32'(bus.ovf_o),  32'd0);

        $display("txn X=7FFF Y=0000");
        drive(1'b1, 16'h7FFF, 16'h0000, 1'b1);
        tick;
        chk("t5_exp_o", 32'(bus.exp_o), 32'h7FFF);
        chk("t5_ovf_o", 32'(bus.ovf_o), 32'd0);
        drive(1'b0, 16'h0000, 16'h0000, 1'b1);
        tick;

        $display("txn backpressure A,B,C");
        drive(1'b1, 16'h1111, 16'h0101, 1'b0);
        tick;
        chk("bp_a_in_ready", 32'(bus.in_ready), 32'd1);
        drive(1'b1, 16'h2222, 16'h0202, 1'b0);
        tick;
        chk("bp_b_in_ready", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 16'h3333, 16'h0303, 1'b0);
        tick;
        chk("bp_c_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_head_a",     32'(bus.cosh_o),   32'h1111);
        drive(1'b0, 16'h0000, 16'h0000, 1'b1);
        tick;
        chk("bp_head_b",     32'(bus.cosh_o),   32'h2222);
        chk("bp_head_b_y",   32'(bus.sinh_o),   32'h0202);
        tick;
        chk("bp_drained",    32'(bus.out_valid), 32'd0);

        $display("txn reset while full");
        drive(1'b1, 16'h6000, 16'h3000, 1'b0);
        tick;
        tick;
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        drive(1'b1, 16'h6000, 16'h3000, 1'b1);
        tick;
        rst = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000, 1'b0);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("mid_rst_sat_cnt",   32'(bus.sat_cnt),   32'd0);
        tick;
        chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

        $display("txn sat_cnt saturation run");
        drive(1'b1, 16'h6000, 16'h3000, 1'b1);
        for (int i = 0; i < 65535; i++) begin
            tick;
            if (i == 999) chk("sat_cnt_1000", 32'(bus.sat_cnt), 32'd1000);
        end
        chk("sat_cnt_ffff", 32'(bus.sat_cnt), 32'hFFFF);
        tick;
        tick;
        chk("sat_cnt_hold", 32'(bus.sat_cnt), 32'hFFFF);
        drive(1'b0, 16'h0000, 16'h0000, 1'b1);
        tick;
        tick;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
